// File: rtl/ring_counter_param.sv
// ring_counter_param
//   N-bit shift counter, selectable at build time as a ring (one-hot,
//   period N) or Johnson (twisted-ring, period 2N) sequence. Runtime step
//   enable, direction and synchronous parallel load; pos tracks the step
//   index modulo the period and wrap pulses for one cycle after pos rolls
//   over. Drop-in for the fixed 4-bit ring counter with N=4, MODE=0, en=1.
//
// Parameters
//   N     counter width, >= 2
//   MODE  0 = ring, 1 = Johnson
//   PW    derived width of pos, $clog2(PERIOD)
//
// Ports
//   clk       in   rising-edge clock
//   clr       in   asynchronous reset, active-high (q = SEED, pos = 0, wrap = 0)
//   en        in   advance one step per clock edge while high
//   dir       in   0 = shift toward MSB, 1 = shift toward LSB
//   load      in   synchronous parallel load, wins over en
//   load_val  in   value written to q on load
//   q         out  counter state
//   pos       out  steps since reset/load, modulo PERIOD
//   wrap      out  registered one-cycle pulse on the step where pos wrapped
//   illegal   out  combinational, q is not a legal state for the mode
//
// Build option
//   RING_COUNTER_SELF_CORRECT_EN: when defined, illegal is decoded and an
//   enabled step from an illegal state reloads SEED instead of rotating.
//   When undefined, illegal is tied low and any pattern simply rotates.

module ring_counter_param #(
  parameter int unsigned N    = 4,
  parameter int unsigned MODE = 0,
  localparam int unsigned PERIOD = (MODE != 0) ? 2 * N : N,
  localparam int unsigned PW     = $clog2(PERIOD)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          dir,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  q,
  output logic [PW-1:0] pos,
  output logic          wrap,
  output logic          illegal
);

  // Ring starts one-hot at bit 0; Johnson starts all-zero.
  localparam logic [N-1:0] SEED = (MODE != 0) ? {N{1'b0}} : {{(N-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

  logic [N-1:0]  q_rot;
  logic [PW-1:0] pos_step;
  logic          wrap_step;
  logic [N-1:0]  q_nxt;
  logic [PW-1:0] pos_nxt;
  logic          wrap_nxt;

`ifdef RING_COUNTER_SELF_CORRECT_EN
  // Johnson legal states have at most two cyclic bit transitions.
  always_comb begin
    illegal = 1'b0;
    if (MODE == 0) begin
      illegal = ($countones(q) != 1);
    end else begin
      illegal = ($countones(q ^ {q[0], q[N-1:1]}) > 2);
    end
  end
`else
  assign illegal = 1'b0;
`endif

  // One step of the sequence in the requested direction.
  always_comb begin
    q_rot = q;
    if (MODE == 0) begin
      q_rot = dir ? {q[0], q[N-1:1]} : {q[N-2:0], q[N-1]};
    end else begin
      q_rot = dir ? {~q[0], q[N-1:1]} : {q[N-2:0], ~q[N-1]};
    end
  end

  // Step index follows direction; wrap marks the modular rollover.
  always_comb begin
    wrap_step = 1'b0;
    pos_step  = pos;
    if (!dir) begin
      wrap_step = (pos == LAST);
      pos_step  = wrap_step ? '0 : pos + PW'(1);
    end else begin
      wrap_step = (pos == '0);
      pos_step  = wrap_step ? LAST : pos - PW'(1);
    end
  end

  // Priority: load > enabled step > hold. Hold still drops wrap.
  always_comb begin
    q_nxt    = q;
    pos_nxt  = pos;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt   = load_val;
      pos_nxt = '0;
    end else if (en) begin
`ifdef RING_COUNTER_SELF_CORRECT_EN
      if (illegal) begin
        q_nxt   = SEED;
        pos_nxt = '0;
      end else
`endif
      begin
        q_nxt    = q_rot;
        pos_nxt  = pos_step;
        wrap_nxt = wrap_step;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q    <= SEED;
      pos  <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      pos  <= pos_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_ring_counter_param.sv
module tb_ring_counter_param;

`ifdef RING_COUNTER_SELF_CORRECT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic clk;
  logic [2:0] clr, ien, idir, ild;
  int unsigned ilv [3];

  logic [3:0] lv0, lv1;
  logic [4:0] lv2;
  logic [3:0] q0, q1;
  logic [4:0] q2;
  logic [1:0] pos0;
  logic [2:0] pos1, pos2;
  logic [2:0] wrap, ill;

  assign lv0 = 4'(ilv[0]);
  assign lv1 = 4'(ilv[1]);
  assign lv2 = 5'(ilv[2]);

  ring_counter_param #(.N(4), .MODE(0)) dut0 (
    .clk(clk), .clr(clr[0]), .en(ien[0]), .dir(idir[0]), .load(ild[0]),
    .load_val(lv0), .q(q0), .pos(pos0), .wrap(wrap[0]), .illegal(ill[0]));
  ring_counter_param #(.N(4), .MODE(1)) dut1 (
    .clk(clk), .clr(clr[1]), .en(ien[1]), .dir(idir[1]), .load(ild[1]),
    .load_val(lv1), .q(q1), .pos(pos1), .wrap(wrap[1]), .illegal(ill[1]));
  ring_counter_param #(.N(5), .MODE(0)) dut2 (
    .clk(clk), .clr(clr[2]), .en(ien[2]), .dir(idir[2]), .load(ild[2]),
    .load_val(lv2), .q(q2), .pos(pos2), .wrap(wrap[2]), .illegal(ill[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: widths, modes, and state as plain integers.
  int          nn [3] = '{4, 4, 5};
  bit          jm [3] = '{1'b0, 1'b1, 1'b0};
  int unsigned mq [3];
  int unsigned mp [3];
  bit          mw [3];

  function automatic int unsigned period(int d);
    return jm[d] ? 2 * nn[d] : nn[d];
  endfunction

  function automatic int unsigned seed(int d);
    return jm[d] ? 0 : 1;
  endfunction

  function automatic int unsigned m_step(int unsigned v, int n, bit j, bit dr);
    int unsigned top, full, b;
    top  = 1 << (n - 1);
    full = 1 << n;
    if (!dr) begin
      b = v / top;
      return (v * 2) % full + (j ? 1 - b : b);
    end
    b = v % 2;
    return v / 2 + (j ? 1 - b : b) * top;
  endfunction

  function automatic bit m_illegal(int unsigned v, int n, bit j);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (!j) c += (v >> i) % 2;
      else if (((v >> i) % 2) != ((v >> ((i + 1) % n)) % 2)) c++;
    end
    return j ? (c > 2) : (c != 1);
  endfunction

  function automatic int unsigned oq(int d);
    case (d)
      0: return 32'(q0);
      1: return 32'(q1);
      default: return 32'(q2);
    endcase
  endfunction

  function automatic int unsigned op(int d);
    case (d)
      0: return 32'(pos0);
      1: return 32'(pos1);
      default: return 32'(pos2);
    endcase
  endfunction

  // Advance the model on a rising edge, then move 1 ns past it.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      int unsigned p;
      p = period(d);
      if (clr[d]) begin
        mq[d] = seed(d); mp[d] = 0; mw[d] = 0;
      end else if (ild[d]) begin
        mq[d] = ilv[d] % (1 << nn[d]); mp[d] = 0; mw[d] = 0;
      end else if (ien[d]) begin
        if (SC && m_illegal(mq[d], nn[d], jm[d])) begin
          mq[d] = seed(d); mp[d] = 0; mw[d] = 0;
        end else begin
          mq[d] = m_step(mq[d], nn[d], jm[d], idir[d]);
          if (!idir[d]) begin
            mp[d] = (mp[d] + 1) % p;
            mw[d] = (mp[d] == 0);
          end else begin
            mw[d] = (mp[d] == 0);
            mp[d] = (mp[d] + p - 1) % p;
          end
        end
      end else begin
        mw[d] = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    ien = '0; idir = '0; ild = '0;
    for (int d = 0; d < 3; d++) ilv[d] = 0;
  endtask

  // Mid-cycle asynchronous reset of all three counters.
  task automatic test_reset();
    idle();
    #3 clr = '1;
    #2;
    for (int d = 0; d < 3; d++) begin
      mq[d] = seed(d); mp[d] = 0; mw[d] = 0;
      n_cmp += 3;
      if (oq(d) !== seed(d)) begin
        n_bad++; $display("FAIL reset_q[%0d]: got %0h want %0h", d, oq(d), seed(d));
      end
      if (op(d) !== 0) begin
        n_bad++; $display("FAIL reset_pos[%0d]: got %0d want 0", d, op(d));
      end
      if (wrap[d] !== 1'b0) begin
        n_bad++; $display("FAIL reset_wrap[%0d]: got %b want 0", d, wrap[d]);
      end
    end
    #1 clr = '0;
  endtask

  task automatic test_ring_left();
    int unsigned eq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int unsigned ep [4] = '{1, 2, 3, 0};
    bit          ew [4] = '{0, 0, 0, 1};
    test_reset();
    ien[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp += 3;
      if (oq(0) !== eq[i]) begin
        n_bad++; $display("FAIL ring_left_q step %0d: got %b want %b", i, q0, 4'(eq[i]));
      end
      if (op(0) !== ep[i]) begin
        n_bad++; $display("FAIL ring_left_pos step %0d: got %0d want %0d", i, pos0, ep[i]);
      end
      if (wrap[0] !== ew[i]) begin
        n_bad++; $display("FAIL ring_left_wrap step %0d: got %b want %b", i, wrap[0], ew[i]);
      end
    end
    idle();
  endtask

  task automatic test_johnson();
    int unsigned lq [8] = '{1, 3, 7, 15, 14, 12, 8, 0};
    int unsigned rq [8] = '{8, 12, 14, 15, 7, 3, 1, 0};
    for (int r = 0; r < 2; r++) begin
      test_reset();
      ien[1] = 1'b1;
      idir[1] = (r == 1);
      for (int i = 0; i < 8; i++) begin
        int unsigned xq, xp;
        bit xw;
        tick();
        xq = (r == 0) ? lq[i] : rq[i];
        xp = (r == 0) ? (i + 1) % 8 : 7 - i;
        xw = (r == 0) ? (i == 7) : (i == 0);
        n_cmp += 3;
        if (oq(1) !== xq) begin
          n_bad++; $display("FAIL johnson_q dir=%0d step %0d: got %b want %b", r, i, q1, 4'(xq));
        end
        if (op(1) !== xp) begin
          n_bad++; $display("FAIL johnson_pos dir=%0d step %0d: got %0d want %0d", r, i, pos1, xp);
        end
        if (wrap[1] !== xw) begin
          n_bad++; $display("FAIL johnson_wrap dir=%0d step %0d: got %b want %b", r, i, wrap[1], xw);
        end
      end
      idle();
    end
  endtask

  task automatic test_hold_load();
    test_reset();
    ien[0] = 1'b1;
    tick(); tick();
    ien[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp += 3;
      if (q0 !== 4'b0100) begin
        n_bad++; $display("FAIL hold_q: got %b want 0100", q0);
      end
      if (pos0 !== 2'd2) begin
        n_bad++; $display("FAIL hold_pos: got %0d want 2", pos0);
      end
      if (wrap[0] !== 1'b0) begin
        n_bad++; $display("FAIL hold_wrap: got %b want 0", wrap[0]);
      end
    end
    ild[0] = 1'b1; ien[0] = 1'b1; ilv[0] = 4'b1000;
    tick();
    n_cmp += 2;
    if (q0 !== 4'b1000) begin
      n_bad++; $display("FAIL load_q: got %b want 1000", q0);
    end
    if (pos0 !== 2'd0) begin
      n_bad++; $display("FAIL load_pos: got %0d want 0", pos0);
    end
    // Reload the same value: pos must still return to 0.
    ild[0] = 1'b0;
    tick();
    ild[0] = 1'b1; ilv[0] = 4'b0001;
    tick();
    n_cmp += 1;
    if (pos0 !== 2'd0) begin
      n_bad++; $display("FAIL load_same_pos: got %0d want 0", pos0);
    end
    idle();
  endtask

  task automatic test_async_clr();
    test_reset();
    ien[0] = 1'b1;
    tick(); tick();
    #3 clr[0] = 1'b1;
    #1;
    n_cmp += 3;
    if (q0 !== 4'b0001) begin
      n_bad++; $display("FAIL async_clr_q: got %b want 0001", q0);
    end
    if (pos0 !== 2'd0) begin
      n_bad++; $display("FAIL async_clr_pos: got %0d want 0", pos0);
    end
    if (wrap[0] !== 1'b0) begin
      n_bad++; $display("FAIL async_clr_wrap: got %b want 0", wrap[0]);
    end
    #1 clr[0] = 1'b0;
    mq[0] = 1; mp[0] = 0; mw[0] = 0;
    tick();
    n_cmp += 2;
    if (q0 !== 4'b0010) begin
      n_bad++; $display("FAIL after_clr_q: got %b want 0010", q0);
    end
    if (pos0 !== 2'd1) begin
      n_bad++; $display("FAIL after_clr_pos: got %0d want 1", pos0);
    end
    idle();
  endtask

  task automatic test_illegal();
    test_reset();
    ild[0] = 1'b1; ilv[0] = 4'b0101;
    tick();
    n_cmp += 1;
    if (ill[0] !== SC) begin
      n_bad++; $display("FAIL illegal_flag: got %b want %b", ill[0], SC);
    end
    ild[0] = 1'b0; ien[0] = 1'b1;
    tick();
    n_cmp += 3;
    if (q0 !== (SC ? 4'b0001 : 4'b1010)) begin
      n_bad++; $display("FAIL illegal_step_q: got %b want %b", q0, SC ? 4'b0001 : 4'b1010);
    end
    if (pos0 !== (SC ? 2'd0 : 2'd1)) begin
      n_bad++; $display("FAIL illegal_step_pos: got %0d want %0d", pos0, SC ? 0 : 1);
    end
    if (ill[0] !== 1'b0) begin
      n_bad++; $display("FAIL illegal_after: got %b want 0", ill[0]);
    end
    idle();
  endtask

  task automatic test_n5();
    int wraps;
    int unsigned xp [4] = '{2, 1, 0, 4};
    test_reset();
    ien[2] = 1'b1;
    wraps = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wrap[2] === 1'b1) wraps++;
    end
    n_cmp += 3;
    if (wraps != 1) begin
      n_bad++; $display("FAIL n5_wrap_count: got %0d want 1", wraps);
    end
    if (q2 !== 5'b00001) begin
      n_bad++; $display("FAIL n5_period_q: got %b want 00001", q2);
    end
    if (pos2 !== 3'd0) begin
      n_bad++; $display("FAIL n5_period_pos: got %0d want 0", pos2);
    end
    tick(); tick(); tick();
    idir[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp += 2;
      if (op(2) !== xp[i]) begin
        n_bad++; $display("FAIL n5_rev_pos step %0d: got %0d want %0d", i, pos2, xp[i]);
      end
      if (wrap[2] !== (i == 3)) begin
        n_bad++; $display("FAIL n5_rev_wrap step %0d: got %b want %b", i, wrap[2], i == 3);
      end
    end
    idle();
  endtask

  task automatic test_random();
    test_reset();
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 3; d++) begin
        ien[d]  = ($urandom_range(0, 3) != 0);
        idir[d] = ($urandom_range(0, 7) == 0) ? ~idir[d] : idir[d];
        ild[d]  = ($urandom_range(0, 9) == 0);
        ilv[d]  = $urandom_range(0, (1 << nn[d]) - 1);
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        bit xi;
        xi = SC && m_illegal(mq[d], nn[d], jm[d]);
        n_cmp += 4;
        if (oq(d) !== mq[d]) begin
          n_bad++; $display("FAIL rand_q[%0d] cyc %0d: got %0h want %0h", d, c, oq(d), mq[d]);
        end
        if (op(d) !== mp[d]) begin
          n_bad++; $display("FAIL rand_pos[%0d] cyc %0d: got %0d want %0d", d, c, op(d), mp[d]);
        end
        if (wrap[d] !== mw[d]) begin
          n_bad++; $display("FAIL rand_wrap[%0d] cyc %0d: got %b want %b", d, c, wrap[d], mw[d]);
        end
        if (ill[d] !== xi) begin
          n_bad++; $display("FAIL rand_illegal[%0d] cyc %0d: got %b want %b", d, c, ill[d], xi);
        end
      end
    end
    idle();
  endtask

  initial begin
    clr = '1;
    idle();
    test_reset();
    test_ring_left();
    test_johnson();
    test_hold_load();
    test_async_clr();
    test_illegal();
    test_n5();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
